// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default widths for the pipeline stage register.
package pipe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 8;
  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one {data, ctrl} holding register; clr zeroes only the ctrl field.
module pipe_slot #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     clr,
  input  logic [DATA_W+CTRL_W-1:0] d,
  output logic [DATA_W+CTRL_W-1:0] q
);
  logic [DATA_W+CTRL_W-1:0] r_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_q <= '0;
    else if (clr) r_q[CTRL_W-1:0] <= '0;
    else if (load) r_q <= d;
  assign q = r_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-slot (main + skid) valid/ready pipeline register with flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  state_t r_state, w_next;
  logic r_in_ready;
  logic w_in_xfer, w_out_xfer, w_main_ld, w_skid_ld;
  logic [DATA_W+CTRL_W-1:0] w_in_word, w_main_d, w_main_q, w_skid_q;
  assign w_in_word  = {in_data, in_ctrl};
  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = out_valid & out_ready;
  assign w_main_d   = (r_state == FULL) ? w_skid_q : w_in_word;
  always_comb begin
    w_next    = r_state;
    w_main_ld = 1'b0;
    w_skid_ld = 1'b0;
    case (r_state)
      EMPTY: begin
        w_next    = w_in_xfer ? HALF : EMPTY;
        w_main_ld = w_in_xfer;
      end
      HALF: begin
        w_next    = w_in_xfer ? (out_ready ? HALF : FULL) : (w_out_xfer ? EMPTY : HALF);
        w_main_ld = w_in_xfer & out_ready;
        w_skid_ld = w_in_xfer & ~out_ready;
      end
      FULL: begin
        w_next    = w_out_xfer ? HALF : FULL;
        w_main_ld = w_out_xfer;
      end
      default: w_next = EMPTY;
    endcase
    if (flush) begin
      w_next    = EMPTY;
      w_main_ld = 1'b0;
      w_skid_ld = 1'b0;
    end
  end
  // in_ready is derived from the next state so it never sees out_ready combinationally
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != FULL);
    end
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk(clk), .rst(rst), .load(w_main_ld), .clr(flush), .d(w_main_d), .q(w_main_q)
  );
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk(clk), .rst(rst), .load(w_skid_ld), .clr(flush), .d(w_in_word), .q(w_skid_q)
  );
  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = w_main_q[DATA_W+CTRL_W-1:CTRL_W];
  assign out_ctrl  = out_valid ? w_main_q[CTRL_W-1:0] : '0;
  assign occupancy = r_state;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random-handshake checks of pipe_stage_reg.
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] in_data = '0, out_data;
  logic [7:0]  in_ctrl = '0, out_ctrl;
  logic [1:0]  occupancy;
  int checks = 0, errors = 0;
  logic [39:0] q[$];
  always #5 clk = ~clk;
  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c, input logic r);
    in_valid = v; in_data = d; in_ctrl = c; out_ready = r;
  endtask
  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", in_ready, 0);
    step();
    rst = 1'b1;
    chk("rel_in_ready_before_edge", in_ready, 0);
    step();
    chk("rel_in_ready", in_ready, 1);
    // streaming: one-cycle latency, occupancy stays 1
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h10 + i, 8'(i + 1), 1);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, 32'h10 + i);
      chk("stream_ctrl", out_ctrl, i + 1);
      chk("stream_occ", occupancy, 1);
    end
    drive(0, 0, 0, 1);
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_ctrl", out_ctrl, 0);
    chk("drain_occ", occupancy, 0);
    // backpressure
    drive(1, 32'hA0, 8'h11, 0);
    step();
    chk("bp_half_occ", occupancy, 1);
    drive(1, 32'hA1, 8'h22, 0);
    step();
    chk("bp_full_occ", occupancy, 2);
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_full_data", out_data, 32'hA0);
    drive(1, 32'hA2, 8'h33, 0);
    step();
    chk("bp_hold_data", out_data, 32'hA0);
    chk("bp_hold_ctrl", out_ctrl, 8'h11);
    chk("bp_hold_occ", occupancy, 2);
    drive(0, 0, 0, 1);
    step();
    chk("bp_second_data", out_data, 32'hA1);
    chk("bp_second_ctrl", out_ctrl, 8'h22);
    chk("bp_second_occ", occupancy, 1);
    chk("bp_second_in_ready", in_ready, 1);
    step();
    chk("bp_empty_valid", out_valid, 0);
    // flush in HALF with an input transfer on the same edge
    drive(1, 32'hB0, 8'h44, 0);
    step();
    drive(1, 32'h55, 8'hFF, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 0, 0, 1);
    chk("flh_occ", occupancy, 0);
    chk("flh_valid", out_valid, 0);
    chk("flh_ctrl", out_ctrl, 0);
    chk("flh_in_ready", in_ready, 1);
    step();
    chk("flh_no55_valid", out_valid, 0);
    // flush in FULL with input presented
    drive(1, 32'hC0, 8'h01, 0);
    step();
    drive(1, 32'hC1, 8'h02, 0);
    step();
    chk("flf_pre_occ", occupancy, 2);
    drive(1, 32'h55, 8'hFF, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 0, 0, 1);
    chk("flf_occ", occupancy, 0);
    chk("flf_valid", out_valid, 0);
    chk("flf_ctrl", out_ctrl, 0);
    step();
    chk("flf_no55_valid", out_valid, 0);
    drive(1, 32'hD0, 8'h05, 1);
    step();
    chk("post_flush_data", out_data, 32'hD0);
    chk("post_flush_ctrl", out_ctrl, 8'h05);
    drive(0, 0, 0, 1);
    step();
    // random handshake with scoreboard
    begin
      int xfers = 0;
      for (int cyc = 0; cyc < 20000 && xfers < 1000; cyc++) begin
        logic ix, ox;
        logic [39:0] seen;
        drive($urandom_range(0, 3) != 0, $urandom, 8'($urandom_range(1, 255)), $urandom_range(0, 2) != 0);
        ix = in_valid & in_ready;
        ox = out_valid & out_ready;
        seen = {out_data, out_ctrl};
        if (!out_valid) chk("rnd_ctrl_zero", out_ctrl, 0);
        step();
        if (ox) begin
          if (q.size() == 0) chk("rnd_underflow", 1, 0);
          else chk("rnd_order", seen, q.pop_front());
          xfers++;
        end
        if (ix) q.push_back({in_data, in_ctrl});
        chk("rnd_occ", occupancy, q.size());
      end
      chk("rnd_count", xfers, 1000);
    end
    // async reset in FULL
    drive(1, 32'h1, 8'h7, 0);
    step();
    drive(1, 32'hDEAD_BEEF, 8'h9, 0);
    while (occupancy != 2 && checks < 100000) step();
    chk("ar_pre_occ", occupancy, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ctrl", out_ctrl, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_data", out_data, 0);
    chk("ar_in_ready", in_ready, 0);
    drive(0, 0, 0, 1);
    step();
    rst = 1'b1;
    step();
    chk("ar_rel_in_ready", in_ready, 1);
    chk("ar_rel_valid", out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, payload bits (PC/Val1/Val2/Reg2/dest style fields) that are held but never cleared on flush.
REQ-002 Parameter CTRL_W, default 8, control bits (EXE_cmd, MEM_R_en, MEM_W_en, WB_en, Br_taken style) that are forced to 0 on flush/bubble.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserting low clears all state immediately, independent of clk.
REQ-005 in_valid  input  1  upstream stage presents a valid instruction.
REQ-006 in_ready  output  1  stage can accept; a transfer occurs when in_valid && in_ready at a clk edge.
REQ-007 in_data  input  DATA_W  payload from upstream.
REQ-008 in_ctrl  input  CTRL_W  control bits from upstream.
REQ-009 flush  input  1  synchronous kill of all held entries (branch taken / hazard).
REQ-010 out_valid  output  1  stage presents a valid instruction downstream.
REQ-011 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-012 out_data  output  DATA_W  payload to downstream.
REQ-013 out_ctrl  output  CTRL_W  control bits; SHALL read 0 whenever out_valid is 0.
REQ-014 occupancy  output  2  number of held entries (0..2).

Function
REQ-015 Storage SHALL be two slots: main (drives outputs) and skid (catches one entry when downstream stalls after in_ready was already high).
REQ-016 States: EMPTY (0 held), HALF (main held), FULL (main+skid held); occupancy SHALL equal 0/1/2 respectively.
REQ-017 in_ready SHALL be a registered signal, 1 in EMPTY and HALF, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-018 out_valid SHALL be 1 in HALF and FULL, 0 in EMPTY; out_data/out_ctrl SHALL come from main slot only.
REQ-019 EMPTY: input transfer -> HALF, main loads input; otherwise stay.
REQ-020 HALF: input only -> FULL if out_ready=0 (skid loads), stay HALF if out_ready=1 (main reloads); output only -> EMPTY; neither -> stay.
REQ-021 FULL: output transfer -> HALF, skid moves to main same edge; no input accepted.
REQ-022 Latency: input transfer at edge N SHALL appear on outputs after edge N (one-cycle latency) when downstream is not stalled; sustained throughput 1 per cycle with out_ready held 1.
REQ-023 Ordering SHALL be strict FIFO; no entry is ever dropped or duplicated absent flush.
REQ-024 flush=1 at an edge SHALL move to EMPTY, clear out_ctrl and skid ctrl to 0, and discard any simultaneous input transfer; flush has priority over every other event.
REQ-025 Payload bits need not be cleared on flush; control bits SHALL be.
REQ-026 Slots SHALL load only on a transfer; held data SHALL be stable while out_valid && !out_ready.

Reset
REQ-027 On rst low: state EMPTY, occupancy 0, in_ready 0 while rst is low, out_valid 0, out_ctrl 0, out_data 0, skid contents 0.
REQ-028 First edge with rst high SHALL set in_ready to 1; reset asserted mid-transfer SHALL discard all held entries with no partial output.

Structure
REQ-029 Shared package pipe_pkg SHALL hold the state enum (EMPTY, HALF, FULL) and default DATA_W/CTRL_W constants.
REQ-030 One sub-module pipe_slot (width DATA_W+CTRL_W, load enable, ctrl clear, async active-low reset) SHALL be instantiated twice for main and skid.

Verification
REQ-031 Reset: rst low mid-FULL with in_data=32'hDEAD_BEEF -> out_valid 0, out_ctrl 0, occupancy 0 immediately, in_ready 1 one edge after release.
REQ-032 Streaming: 8 inputs 0x10..0x17, out_ready=1 -> outputs 0x10..0x17 on 8 consecutive cycles, 1-cycle latency, occupancy stays 1.
REQ-033 Backpressure: out_ready=0 after loading 0xA0 and 0xA1 -> FULL, in_ready 0, out_data holds 0xA0; out_ready=1 -> 0xA0 then 0xA1, no loss.
REQ-034 Flush with simultaneous input 0x55, in_ctrl=8'hFF in FULL -> next cycle EMPTY, out_valid 0, out_ctrl 0, 0x55 never appears.
REQ-035 Random valid/ready toggling, 1000 transfers -> scoreboard order match, out_ctrl 0 whenever out_valid 0.
